// File: rtl/conv2_frame_ctrl.sv
// conv2_frame_ctrl: frame sequencer between pool1 and the conv2 layer.
// Clears conv2, streams one 12x12x3 frame in, tags the 8x8 output map.
module conv2_frame_ctrl #(
    parameter int WIDTH       = 12,
    parameter int HEIGHT      = 12,
    parameter int KERNEL      = 5,
    parameter int DATA_BITS   = 12,
    parameter int CLR_CYCLES  = 2,
    parameter int OUT_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data_1,
    input  logic [DATA_BITS-1:0] in_data_2,
    input  logic [DATA_BITS-1:0] in_data_3,
    output logic                 in_ready,
    output logic                 layer_valid_in,
    output logic [DATA_BITS-1:0] layer_data_1,
    output logic [DATA_BITS-1:0] layer_data_2,
    output logic [DATA_BITS-1:0] layer_data_3,
    output logic                 layer_rst_n,
    input  logic                 layer_valid_out,
    output logic [2:0]           out_row,
    output logic [2:0]           out_col,
    output logic                 out_tag_valid,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err_timeout
);

    localparam int OUT_W     = WIDTH - KERNEL + 1;
    localparam int OUT_H     = HEIGHT - KERNEL + 1;
    localparam int IN_BEATS  = WIDTH * HEIGHT;
    localparam int OUT_BEATS = OUT_W * OUT_H;

    localparam int IN_CW  = $clog2(IN_BEATS);
    localparam int OUT_CW = $clog2(OUT_BEATS);
    localparam int CLR_CW = $clog2(CLR_CYCLES + 1);
    localparam int TMO_CW = $clog2(OUT_TIMEOUT + 1);

    localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(IN_BEATS - 1);
    localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(OUT_BEATS - 1);
    localparam logic [CLR_CW-1:0] CLR_LAST = CLR_CW'(CLR_CYCLES - 1);
    localparam logic [TMO_CW-1:0] TMO_LAST = TMO_CW'(OUT_TIMEOUT - 1);
    localparam logic [2:0]        COL_LAST = 3'(OUT_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        DRAIN,
        DONE,
        ERR
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [CLR_CW-1:0] clr_cnt_q;
    logic [CLR_CW-1:0] clr_cnt_d;
    logic [IN_CW-1:0]  in_cnt_q;
    logic [IN_CW-1:0]  in_cnt_d;
    logic [OUT_CW-1:0] out_cnt_q;
    logic [OUT_CW-1:0] out_cnt_d;
    logic [2:0]        row_q;
    logic [2:0]        row_d;
    logic [2:0]        col_q;
    logic [2:0]        col_d;
    logic [TMO_CW-1:0] tmo_cnt_q;
    logic [TMO_CW-1:0] tmo_cnt_d;

    logic                 lvi_q;
    logic                 lvi_d;
    logic [DATA_BITS-1:0] d1_q;
    logic [DATA_BITS-1:0] d1_d;
    logic [DATA_BITS-1:0] d2_q;
    logic [DATA_BITS-1:0] d2_d;
    logic [DATA_BITS-1:0] d3_q;
    logic [DATA_BITS-1:0] d3_d;

    logic accept;
    logic counting;
    logic out_hit;
    logic in_last;
    logic out_last;
    logic clr_last;
    logic tmo_hit;

    // Handshake and event qualifiers decoded from the current state.
    always_comb begin
        accept   = in_valid && (state_q == LOAD);
        counting = (state_q == LOAD) || (state_q == DRAIN);
        out_hit  = counting && layer_valid_out;
        in_last  = accept && (in_cnt_q == IN_LAST);
        out_last = out_hit && (out_cnt_q == OUT_LAST);
        clr_last = (clr_cnt_q == CLR_LAST);
        tmo_hit  = (state_q == DRAIN)
                && !layer_valid_out
                && (tmo_cnt_q == TMO_LAST);
    end

    // Next-state logic; a finished output map wins over the last input beat.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = CLEAR;
            end
            CLEAR: begin
                if (clr_last) state_d = LOAD;
            end
            LOAD: begin
                if (out_last) state_d = DONE;
                else if (in_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_last) state_d = DONE;
                else if (tmo_hit) state_d = ERR;
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                if (start) state_d = CLEAR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame counters: cleared in CLEAR, output tags advance in raster order.
    always_comb begin
        clr_cnt_d = '0;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        tmo_cnt_d = '0;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + CLR_CW'(1);
            in_cnt_d  = '0;
            out_cnt_d = '0;
            row_d     = '0;
            col_d     = '0;
        end
        if (accept) begin
            in_cnt_d = in_cnt_q + IN_CW'(1);
        end
        if (out_hit) begin
            out_cnt_d = out_cnt_q + OUT_CW'(1);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 3'(1);
            end else begin
                col_d = col_q + 3'(1);
            end
        end
        if ((state_q == DRAIN) && !layer_valid_out) begin
            tmo_cnt_d = tmo_cnt_q + TMO_CW'(1);
        end
    end

    // Beat register towards conv2; samples hold across input gaps.
    always_comb begin
        lvi_d = accept;
        d1_d  = accept ? in_data_1 : d1_q;
        d2_d  = accept ? in_data_2 : d2_q;
        d3_d  = accept ? in_data_3 : d3_q;
    end

    // State, counter and beat registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            tmo_cnt_q <= '0;
            lvi_q     <= 1'b0;
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            row_q     <= row_d;
            col_q     <= col_d;
            tmo_cnt_q <= tmo_cnt_d;
            lvi_q     <= lvi_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            d3_q      <= d3_d;
        end
    end

    // Status outputs decoded straight from state; the layer clear
    // also follows rst so conv2 is held while this block resets.
    always_comb begin
        in_ready       = (state_q == LOAD);
        busy           = (state_q != IDLE);
        frame_done     = (state_q == DONE);
        err_timeout    = (state_q == ERR);
        layer_rst_n    = !(rst || (state_q == CLEAR));
        out_tag_valid  = out_hit;
        out_row        = row_q;
        out_col        = col_q;
        layer_valid_in = lvi_q;
        layer_data_1   = d1_q;
        layer_data_2   = d2_q;
        layer_data_3   = d3_q;
    end

endmodule

// File: tb/tb_conv2_frame_ctrl.sv
// tb_conv2_frame_ctrl: scoreboard bench for the conv2 frame sequencer.
// A raster conv2 model drives layer_valid_out; beats and tags are queued.
module tb_conv2_frame_ctrl;

    localparam int DB        = 12;
    localparam int IN_BEATS  = 144;
    localparam int OUT_BEATS = 64;
    localparam int BUDGET    = 3000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DB-1:0] in_data_1 = '0;
    logic [DB-1:0] in_data_2 = '0;
    logic [DB-1:0] in_data_3 = '0;
    logic          layer_valid_out = 1'b0;

    logic          in_ready;
    logic          layer_valid_in;
    logic [DB-1:0] layer_data_1;
    logic [DB-1:0] layer_data_2;
    logic [DB-1:0] layer_data_3;
    logic          layer_rst_n;
    logic [2:0]    out_row;
    logic [2:0]    out_col;
    logic          out_tag_valid;
    logic          busy;
    logic          frame_done;
    logic          err_timeout;

    int tests_run = 0;
    int tests_failed = 0;

    logic [3*DB-1:0] data_q[$];
    logic [5:0]      tag_q[$];

    int beats = 0;
    int outs = 0;
    int lvi_cnt = 0;
    int edges = 0;
    int last_out_edge = 0;
    bit poke_start = 1'b0;
    bit hold_ok = 1'b0;
    logic [3*DB-1:0] last_data = '0;

    conv2_frame_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .in_valid        (in_valid),
        .in_data_1       (in_data_1),
        .in_data_2       (in_data_2),
        .in_data_3       (in_data_3),
        .in_ready        (in_ready),
        .layer_valid_in  (layer_valid_in),
        .layer_data_1    (layer_data_1),
        .layer_data_2    (layer_data_2),
        .layer_data_3    (layer_data_3),
        .layer_rst_n     (layer_rst_n),
        .layer_valid_out (layer_valid_out),
        .out_row         (out_row),
        .out_col         (out_col),
        .out_tag_valid   (out_tag_valid),
        .busy            (busy),
        .frame_done      (frame_done),
        .err_timeout     (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges++;

    // Beat monitor: each registered beat must match the oldest accepted one.
    always @(posedge clk) begin : mon
        logic r;
        logic [3*DB-1:0] got;
        logic [3*DB-1:0] exp_d;
        r = rst;
        #5;
        got = {layer_data_1, layer_data_2, layer_data_3};
        if (r) begin
            hold_ok = 1'b0;
        end else if (layer_valid_in === 1'b1) begin
            tests_run++;
            lvi_cnt++;
            if (data_q.size() == 0) begin
                tests_failed++;
                $display("FAIL beat_unexpected got=%h exp=no beat", got);
            end else begin
                exp_d = data_q.pop_front();
                if (got !== exp_d) begin
                    tests_failed++;
                    $display("FAIL beat_data got=%h exp=%h", got, exp_d);
                end
            end
            hold_ok = 1'b1;
            last_data = got;
        end else if (hold_ok) begin
            tests_run++;
            if (layer_valid_in !== 1'b0 || got !== last_data) begin
                tests_failed++;
                $display("FAIL beat_hold vld=%b got=%h exp=%h",
                         layer_valid_in, got, last_data);
            end
        end
    end

    task automatic start_frame();
        beats = 0;
        outs = 0;
        lvi_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (layer_rst_n !== 1'b0 || busy !== 1'b1 ||
            in_ready !== 1'b0 || err_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_c1 rst_n=%b busy=%b rdy=%b err=%b exp=0 1 0 0",
                     layer_rst_n, busy, in_ready, err_timeout);
        end
        @(posedge clk); #1;
        tests_run++;
        if (layer_rst_n !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_c2 rst_n=%b rdy=%b exp=0 0",
                     layer_rst_n, in_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (layer_rst_n !== 1'b1 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_end rst_n=%b rdy=%b exp=1 1",
                     layer_rst_n, in_ready);
        end
    endtask

    // One LOAD/DRAIN cycle: drive a beat and the conv2 model, check tags.
    // mode 0: raster conv2, 1: outputs early in LOAD, 2: outputs after load.
    task automatic frame_cycle(input bit gap, input int mode,
                               input int out_limit, input int cyc);
        bit lvo;
        bit acc;
        int need;
        logic [5:0] got_t;
        logic [5:0] exp_t;
        in_valid = (beats < IN_BEATS) && (!gap || (cyc % 2) == 0);
        in_data_1 = DB'($urandom);
        in_data_2 = DB'($urandom);
        in_data_3 = DB'($urandom);
        start = poke_start && beats >= 20 && beats < 23;
        lvo = 1'b0;
        if (outs < out_limit) begin
            if (mode == 0) begin
                need = (outs / 8 + 4) * 12 + outs % 8 + 4;
                lvo = beats > need;
            end else if (mode == 1) begin
                lvo = beats >= 10;
            end else begin
                lvo = beats >= IN_BEATS;
            end
        end
        layer_valid_out = lvo;
        if (lvo) begin
            tag_q.push_back({3'(outs / 8), 3'(outs % 8)});
            last_out_edge = edges + 1;
            outs++;
        end
        acc = in_valid && (in_ready === 1'b1);
        if (acc) begin
            data_q.push_back({in_data_1, in_data_2, in_data_3});
            beats++;
        end
        #2;
        tests_run++;
        if (out_tag_valid !== lvo) begin
            tests_failed++;
            $display("FAIL tag_valid got=%b exp=%b", out_tag_valid, lvo);
        end else if (lvo) begin
            tests_run++;
            exp_t = tag_q.pop_front();
            got_t = {out_row, out_col};
            if (got_t !== exp_t) begin
                tests_failed++;
                $display("FAIL tag_rc got=(%0d,%0d) exp=(%0d,%0d)",
                         got_t[5:3], got_t[2:0], exp_t[5:3], exp_t[2:0]);
            end
        end
        @(posedge clk); #1;
    endtask

    // result: 0 done, 1 error, 2 stopped at max_beats, 3 budget expired
    task automatic run_frame(input bit gap, input int mode,
                             input int out_limit, input int max_beats,
                             output int result);
        int cyc;
        bit stop;
        cyc = 0;
        stop = 1'b0;
        result = 3;
        while (!stop) begin
            if (frame_done === 1'b1) begin
                result = 0;
                stop = 1'b1;
            end else if (err_timeout === 1'b1) begin
                result = 1;
                stop = 1'b1;
            end else if (beats >= max_beats) begin
                result = 2;
                stop = 1'b1;
            end else if (cyc >= BUDGET) begin
                stop = 1'b1;
            end else begin
                tests_run++;
                if (in_ready !== (beats < IN_BEATS) || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL phase beats=%0d rdy=%b busy=%b exp=%b 1",
                             beats, in_ready, busy, beats < IN_BEATS);
                end
                frame_cycle(gap, mode, out_limit, cyc);
                cyc++;
            end
        end
        in_valid = 1'b0;
        layer_valid_out = 1'b0;
        start = 1'b0;
        if (result == 3) begin
            tests_run++;
            tests_failed++;
            $display("FAIL frame_budget got=%0d cycles exp=<%0d", cyc, BUDGET);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (layer_rst_n !== 1'b0 || in_ready !== 1'b0 ||
            layer_valid_in !== 1'b0 || busy !== 1'b0 ||
            frame_done !== 1'b0 || err_timeout !== 1'b0 ||
            out_tag_valid !== 1'b0 || {out_row, out_col} !== 6'd0 ||
            {layer_data_1, layer_data_2, layer_data_3} !== 36'd0) begin
            tests_failed++;
            $display("FAIL reset_vals rst_n=%b rdy=%b lvi=%b busy=%b done=%b err=%b exp=0 0 0 0 0 0",
                     layer_rst_n, in_ready, layer_valid_in, busy,
                     frame_done, err_timeout);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (layer_rst_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release rst_n=%b exp=1", layer_rst_n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        int res;
        start_frame();
        run_frame(1'b0, 0, OUT_BEATS, IN_BEATS + 1, res);
        tests_run++;
        if (res != 0 || beats != IN_BEATS || outs != OUT_BEATS ||
            lvi_cnt != IN_BEATS || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL nominal_end res=%0d beats=%0d outs=%0d lvi=%0d busy=%b exp=0 144 64 144 1",
                     res, beats, outs, lvi_cnt, busy);
        end
        @(posedge clk); #1;
        tests_run++;
        if (frame_done !== 1'b0 || busy !== 1'b0 ||
            data_q.size() != 0 || tag_q.size() != 0) begin
            tests_failed++;
            $display("FAIL nominal_idle done=%b busy=%b dq=%0d tq=%0d exp=0 0 0 0",
                     frame_done, busy, data_q.size(), tag_q.size());
        end
    endtask

    task automatic test_gapped();
        int res;
        start_frame();
        run_frame(1'b1, 0, OUT_BEATS, IN_BEATS + 1, res);
        tests_run++;
        if (res != 0 || beats != IN_BEATS || lvi_cnt != IN_BEATS ||
            outs != OUT_BEATS) begin
            tests_failed++;
            $display("FAIL gapped_end res=%0d beats=%0d lvi=%0d outs=%0d exp=0 144 144 64",
                     res, beats, lvi_cnt, outs);
        end
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || data_q.size() != 0 || tag_q.size() != 0) begin
            tests_failed++;
            $display("FAIL gapped_idle busy=%b dq=%0d tq=%0d exp=0 0 0",
                     busy, data_q.size(), tag_q.size());
        end
    endtask

    task automatic test_ignored();
        int res;
        repeat (3) begin
            layer_valid_out = 1'b1;
            #2;
            tests_run++;
            if (out_tag_valid !== 1'b0 || busy !== 1'b0 ||
                {out_row, out_col} !== 6'd0) begin
                tests_failed++;
                $display("FAIL idle_valid_out tag=%b busy=%b rc=%0d exp=0 0 0",
                         out_tag_valid, busy, {out_row, out_col});
            end
            @(posedge clk); #1;
        end
        layer_valid_out = 1'b0;
        start_frame();
        poke_start = 1'b1;
        run_frame(1'b0, 0, OUT_BEATS, IN_BEATS + 1, res);
        poke_start = 1'b0;
        tests_run++;
        if (res != 0 || beats != IN_BEATS || outs != OUT_BEATS) begin
            tests_failed++;
            $display("FAIL ignored_end res=%0d beats=%0d outs=%0d exp=0 144 64",
                     res, beats, outs);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_early();
        int res;
        start_frame();
        run_frame(1'b0, 1, OUT_BEATS, IN_BEATS + 1, res);
        tests_run++;
        if (res != 0 || beats >= IN_BEATS || outs != OUT_BEATS ||
            in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL early_done res=%0d beats=%0d outs=%0d rdy=%b exp=0 <144 64 0",
                     res, beats, outs, in_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || tag_q.size() != 0) begin
            tests_failed++;
            $display("FAIL early_idle busy=%b done=%b tq=%0d exp=0 0 0",
                     busy, frame_done, tag_q.size());
        end
    endtask

    task automatic test_timeout();
        int res;
        start_frame();
        run_frame(1'b0, 2, 60, IN_BEATS + 1, res);
        tests_run++;
        if (res != 1 || outs != 60 || edges - last_out_edge != 255) begin
            tests_failed++;
            $display("FAIL timeout_err res=%0d outs=%0d idle=%0d exp=1 60 255",
                     res, outs, edges - last_out_edge);
        end
        repeat (3) begin
            @(posedge clk); #1;
            tests_run++;
            if (err_timeout !== 1'b1 || frame_done !== 1'b0 ||
                in_ready !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL err_sticky err=%b done=%b rdy=%b busy=%b exp=1 0 0 1",
                         err_timeout, frame_done, in_ready, busy);
            end
        end
        start_frame();
        run_frame(1'b0, 0, OUT_BEATS, IN_BEATS + 1, res);
        tests_run++;
        if (res != 0 || outs != OUT_BEATS) begin
            tests_failed++;
            $display("FAIL err_restart res=%0d outs=%0d exp=0 64", res, outs);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_midframe_reset();
        int res;
        start_frame();
        run_frame(1'b0, 0, OUT_BEATS, 70, res);
        tests_run++;
        if (res != 2) begin
            tests_failed++;
            $display("FAIL midrst_stop res=%0d exp=2", res);
        end
        rst = 1'b1;
        #2;
        tests_run++;
        if (layer_rst_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_rst_n got=%b exp=0", layer_rst_n);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (layer_rst_n !== 1'b1 || in_ready !== 1'b0 ||
            layer_valid_in !== 1'b0 || busy !== 1'b0 ||
            frame_done !== 1'b0 || err_timeout !== 1'b0 ||
            out_tag_valid !== 1'b0 || {out_row, out_col} !== 6'd0 ||
            {layer_data_1, layer_data_2, layer_data_3} !== 36'd0 ||
            data_q.size() != 0 || tag_q.size() != 0) begin
            tests_failed++;
            $display("FAIL midrst_vals rst_n=%b rdy=%b lvi=%b busy=%b rc=%0d exp=1 0 0 0 0",
                     layer_rst_n, in_ready, layer_valid_in, busy,
                     {out_row, out_col});
        end
        @(posedge clk); #1;
        start_frame();
        run_frame(1'b0, 0, OUT_BEATS, IN_BEATS + 1, res);
        tests_run++;
        if (res != 0 || outs != OUT_BEATS || lvi_cnt != IN_BEATS) begin
            tests_failed++;
            $display("FAIL midrst_frame res=%0d outs=%0d lvi=%0d exp=0 64 144",
                     res, outs, lvi_cnt);
        end
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || tag_q.size() != 0 || data_q.size() != 0) begin
            tests_failed++;
            $display("FAIL midrst_idle busy=%b tq=%0d dq=%0d exp=0 0 0",
                     busy, tag_q.size(), data_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_gapped();
        test_ignored();
        test_early();
        test_timeout();
        test_midframe_reset();
        repeat (2) @(posedge clk);
        #6;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/conv2_frame_ctrl.md
# conv2_frame_ctrl

Frame sequencer for the second convolution layer: admits one 12x12x3 pooled feature frame at a time, forwards it to the conv2 layer with a registered valid, and tracks the 8x8 conv2 output map. It clears the conv2 line buffers before each frame and tags every conv2 output with its row and column. It raises a done pulse after the last output, or a sticky error if the layer stalls. It sits between the pool1 stage and the conv2 layer.

## Interface
- WIDTH, 12, input map width
- HEIGHT, 12, input map height
- KERNEL, 5, conv2 kernel size; output map is (WIDTH-KERNEL+1) x (HEIGHT-KERNEL+1) = 8x8
- DATA_BITS, 12, per-channel sample width
- CLR_CYCLES, 2, cycles the layer reset is held in CLEAR
- OUT_TIMEOUT, 255, maximum idle cycles in DRAIN before error
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- start  in  1  frame start request; honoured only in IDLE or ERR
- in_valid  in  1  upstream sample valid
- in_data_1/2/3  in  DATA_BITS each  channel samples, raster order
- in_ready  out  1  high only in LOAD
- layer_valid_in  out  1  registered beat to conv2 valid_in
- layer_data_1/2/3  out  DATA_BITS each  registered samples to conv2 inputs
- layer_rst_n  out  1  active-low clear to the conv2 layer
- layer_valid_out  in  1  conv2 output valid
- out_row, out_col  out  3 each  coordinates of the current conv2 output
- out_tag_valid  out  1  equals layer_valid_out while counting
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse
- err_timeout  out  1  sticky error flag

## Operation
- States: IDLE, CLEAR, LOAD, DRAIN, DONE, ERR.
- IDLE: in_ready=0. On start, go to CLEAR.
- CLEAR: layer_rst_n=0 for exactly CLR_CYCLES cycles. In_cnt, out_cnt and timeout counter reset to 0. Then go to LOAD.
- LOAD: in_ready=1. Accept a beat when in_valid & in_ready.
  - On an accepted beat: in_cnt increments (0..WIDTH*HEIGHT-1).
  - On the beat accepted with in_cnt=143: go to DRAIN.
- Output counting is active in LOAD and DRAIN.
  - Each layer_valid_out increments out_cnt (0..63).
  - out_col runs 0..7; at 7 it wraps to 0 and out_row increments.
  - out_row/out_col show the coordinates of the current output while out_tag_valid is high.
  - The output with out_cnt=63 moves the FSM to DONE, from either LOAD or DRAIN.
- DRAIN: in_ready=0. The timeout counter increments each cycle without layer_valid_out and clears on layer_valid_out. If it reaches OUT_TIMEOUT, go to ERR.
- DONE: frame_done=1 for one cycle, then go to IDLE.
- ERR: err_timeout=1, in_ready=0. A start clears err_timeout and goes to CLEAR.
- layer_valid_out outside LOAD/DRAIN: ignored, no counting, out_tag_valid=0.
- start in CLEAR, LOAD, DRAIN or DONE: ignored.
- Arithmetic: counters are unsigned and sized by $clog2. Data is passed through untouched, with no sign handling.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=0, layer_valid_in=0, layer_data_*=0
  - layer_rst_n=0 while rst is high, 1 afterwards
  - out_row=0, out_col=0, out_tag_valid=0
  - busy=0, frame_done=0, err_timeout=0
- Reset asserted mid-frame: everything returns to the reset values on the next edge. Partial counts are discarded.
- in_ready is decoded directly from state, with no registering.
- Beat accepted at edge N: layer_valid_in=1 and layer_data_* hold that beat during cycle N+1. Latency is 1 cycle, and throughput is one beat per cycle.
- in_valid low in LOAD: layer_valid_in=0 next cycle and layer_data_* hold their values.
- CLEAR timing: start seen at edge N gives layer_rst_n=0 for cycles N+1..N+CLR_CYCLES. in_ready=1 from cycle N+CLR_CYCLES+1.
- frame_done is high in the cycle after the edge that samples the 64th layer_valid_out. busy drops one cycle later.
- Timeout counts only DRAIN cycles. Entering DRAIN resets the counter to 0.

## Test plan
- Nominal frame:
  - Stimulus: start, then 144 back-to-back beats, with a model conv2 emitting 64 valids.
  - Required: layer_rst_n low exactly 2 cycles; layer_valid_in high 144 cycles, each 1 cycle after acceptance; out_row/out_col step (0,0)..(7,7); one frame_done; busy returns to 0.
- Gapped input:
  - Stimulus: in_valid toggled 1/0.
  - Required: layer_valid_in mirrors accepted beats only; layer_data_* stable during gaps; transition to DRAIN after the 144th accepted beat.
- Timeout:
  - Stimulus: model emits only 60 outputs.
  - Required: err_timeout=1 exactly 255 idle DRAIN cycles after the last output; no frame_done.
  - Then start: err_timeout clears and CLEAR runs.
- Ignored events:
  - Stimulus: start during LOAD, and layer_valid_out pulses while IDLE.
  - Required: no state change, out_cnt unchanged, out_tag_valid=0.
- Mid-frame reset:
  - Stimulus: rst for 1 cycle after 70 beats, then a full frame.
  - Required: all outputs at reset values; the second frame completes normally with 64 tagged outputs.
- Early completion:
  - Stimulus: all 64 outputs arrive while still in LOAD (model fed in raster order).
  - Required: DONE is taken from LOAD, with frame_done after the 64th output.
